// File: rtl/mux_nby1_rr_pkg.sv
// Shared constants and helpers for the N:1 registered channel multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Select width that never collapses to zero bits for tiny channel counts.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mux_nby1_rr_arbiter.sv
// Round-robin arbiter: rotate requests by ptr, pick the first set bit, un-rotate.
// Purely combinational, no latency; no backpressure of its own.
module rr_arbiter
    import mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int SEL_W = clog2_min1(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [2*N_CH-1:0] dbl;
    logic [N_CH-1:0]   rot;
    int                first;
    int                sum;

    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[N_CH-1:0];
        first = 0;
        // Descending scan so the lowest rotated offset (closest to ptr) wins.
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (rot[k]) first = k;
        end
        sum = int'(ptr) + first;
        if (sum >= N_CH) sum = sum - N_CH;
        gnt_idx = SEL_W'(sum);
        gnt_vld = |req;
    end

endmodule

// File: rtl/mux_nby1_rr.sv
// Registered N:1 channel mux, fixed-select or round-robin; 1-cycle latency, 1 word/cycle.
// Backpressure: a stalled output register drops every in_ready and freezes data, channel and ptr.
module mux_nby1_rr
    import mux_pkg::*;
#(
    parameter int N_CH  = 8,
    parameter int WIDTH = 8,
    parameter int SEL_W = clog2_min1(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH*WIDTH-1:0] in_data,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready
);

    logic [SEL_W-1:0] ptr;
    logic [SEL_W-1:0] rr_idx;
    logic             rr_vld;
    logic             fixed_vld;
    logic [SEL_W-1:0] grant;
    logic             grant_vld;
    logic             free;
    logic [WIDTH-1:0] grant_word;

    rr_arbiter #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_arb (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (rr_idx),
        .gnt_vld (rr_vld)
    );

    // Compare-based lookup keeps out-of-range sel values harmless (no grant, no X).
    always_comb begin
        fixed_vld = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel == SEL_W'(i)) fixed_vld = in_valid[i];
        end
    end

    assign grant     = (mode == MODE_RR) ? rr_idx : sel;
    assign grant_vld = (mode == MODE_RR) ? rr_vld : fixed_vld;
    assign free      = !out_valid || out_ready;

    always_comb begin
        grant_word = '0;
        in_ready   = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_word  = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = !rst && free && grant_vld;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
            ptr       <= '0;
        end else if (free) begin
            if (grant_vld) begin
                out_data  <= grant_word;
                out_ch    <= grant;
                out_valid <= 1'b1;
                ptr       <= (grant == SEL_W'(N_CH - 1)) ? '0 : grant + SEL_W'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
